button_conditioner: RTL and testbench



---
 rtl/btn_pkg.sv | 26 ++
 rtl/debounce_channel.sv | 139 +++++++++++++
 rtl/button_conditioner.sv | 44 ++++
 tb/tb_button_conditioner.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_pkg
// Description : Shared timing defaults and repeat-FSM state type for the
//               button conditioning pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

    localparam int CLK_HZ                  = 12_000_000;
    localparam int DEBOUNCE_CYCLES_DEFAULT = CLK_HZ / 100;  // 10 ms
    localparam int HOLD_CYCLES_DEFAULT     = CLK_HZ / 2;    // 0.5 s
    localparam int REPEAT_CYCLES_DEFAULT   = CLK_HZ / 10;   // 100 ms

    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        HOLD_WAIT = 2'd1,
        REPEATING = 2'd2
    } rpt_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : debounce_channel
// Description : One button lane: two-flop synchroniser, polarity fix,
//               debounce counter, press/release strobes and auto-repeat FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
    import btn_pkg::*;
#(
    parameter logic ACTIVE_LOW      = 1'b0,
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int   HOLD_CYCLES     = HOLD_CYCLES_DEFAULT,
    parameter int   REPEAT_CYCLES   = REPEAT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pad,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);

    localparam int c_deb_w = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_rpt_w = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES) + 1);

    localparam logic [c_deb_w-1:0] c_deb_last  = c_deb_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_rpt_w-1:0] c_hold_last = c_rpt_w'(HOLD_CYCLES - 1);
    localparam logic [c_rpt_w-1:0] c_rep_last  = c_rpt_w'(REPEAT_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic [c_deb_w-1:0] r_deb_cnt;
    logic               r_level;
    logic               r_press;
    logic               r_release;
    logic [c_rpt_w-1:0] r_rpt_cnt;
    rpt_state_t         r_state;
    logic               r_repeat;

    logic w_s;
    logic w_differs;
    logic w_accept;
    logic w_accept_press;
    logic w_accept_release;

    // Sync flops reset to the idle pad level so the corrected sample starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= ACTIVE_LOW;
            r_sync2 <= ACTIVE_LOW;
        end else begin
            r_sync1 <= i_pad;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s              = r_sync2 ^ ACTIVE_LOW;
    assign w_differs        = (w_s != r_level);
    assign w_accept         = w_differs && (r_deb_cnt == c_deb_last);
    assign w_accept_press   = w_accept && w_s;
    assign w_accept_release = w_accept && !w_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb_cnt <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (!w_differs) begin
                r_deb_cnt <= '0;
            end else if (w_accept) begin
                r_deb_cnt <= '0;
                r_level   <= w_s;
                r_press   <= w_s;
                r_release <= !w_s;
            end else if (r_deb_cnt != c_deb_last) begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
        end
    end

    // The counter is compared against limit-1 so the strobe, being registered,
    // lands exactly HOLD/REPEAT cycles after the press strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RELEASED;
            r_rpt_cnt <= '0;
            r_repeat  <= 1'b0;
        end else begin
            r_repeat <= 1'b0;
            if (w_accept_release) begin
                r_state   <= RELEASED;
                r_rpt_cnt <= '0;
            end else begin
                case (r_state)
                    RELEASED: begin
                        r_rpt_cnt <= '0;
                        if (w_accept_press) begin
                            r_state <= HOLD_WAIT;
                        end
                    end
                    HOLD_WAIT: begin
                        if (r_rpt_cnt >= c_hold_last) begin
                            r_repeat  <= 1'b1;
                            r_rpt_cnt <= '0;
                            r_state   <= REPEATING;
                        end else begin
                            r_rpt_cnt <= r_rpt_cnt + 1'b1;
                        end
                    end
                    REPEATING: begin
                        if (r_rpt_cnt >= c_rep_last) begin
                            r_repeat  <= 1'b1;
                            r_rpt_cnt <= '0;
                        end else begin
                            r_rpt_cnt <= r_rpt_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state   <= RELEASED;
                        r_rpt_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_repeat  = r_repeat;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Synchronises, debounces and edge-detects the user buttons,
//               producing clean levels, press/release and auto-repeat strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner
    import btn_pkg::*;
#(
    parameter int               N_BTN           = 4,
    parameter logic [N_BTN-1:0] ACTIVE_LOW_MASK = 4'b1000,
    parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int               HOLD_CYCLES     = HOLD_CYCLES_DEFAULT,
    parameter int               REPEAT_CYCLES   = REPEAT_CYCLES_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        debounce_channel #(
            .ACTIVE_LOW      (ACTIVE_LOW_MASK[i]),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_chan (
            .clk       (CLK),
            .rst_n     (RST_N),
            .i_pad     (btn_in[i]),
            .o_level   (btn_level[i]),
            .o_press   (btn_press[i]),
            .o_release (btn_release[i]),
            .o_repeat  (btn_repeat[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Directed self-checking bench for button_conditioner with
//               short debounce/hold/repeat timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int c_deb  = 4;
    localparam int c_hold = 20;
    localparam int c_rep  = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn_in;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic [3:0] btn_repeat;

    int n_tests = 0;
    int n_fail  = 0;

    button_conditioner #(
        .N_BTN           (4),
        .ACTIVE_LOW_MASK (4'b1000),
        .DEBOUNCE_CYCLES (c_deb),
        .HOLD_CYCLES     (c_hold),
        .REPEAT_CYCLES   (c_rep)
    ) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected vector packs {level, press, release, repeat}.
    task automatic check(input string tag, input logic [15:0] exp);
        logic [15:0] obs;
        obs = {btn_level, btn_press, btn_release, btn_repeat};
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one pad change and checks the full debounce latency (6 edges),
    // assuming every other channel is released and no repeat is due.
    task automatic debounce_seq(input int ch, input logic pad, input logic rise, input string tag);
        logic [3:0] m;
        m = 4'(1 << ch);
        btn_in[ch] = pad;
        for (int k = 1; k <= c_deb + 2; k++) begin
            step();
            if (k < c_deb + 2)
                check(tag, {(rise ? 4'b0000 : m), 4'b0000, 4'b0000, 4'b0000});
            else
                check(tag, {(rise ? m : 4'b0000), (rise ? m : 4'b0000),
                            (rise ? 4'b0000 : m), 4'b0000});
        end
        step();
        check(tag, {(rise ? m : 4'b0000), 12'h000});
    endtask

    initial begin
        logic [3:0] rpt;
        logic [3:0] lvl;
        logic [3:0] rel;

        rst_n  = 1'b0;
        btn_in = 4'b1000;
        #2;
        check("reset_values", 16'h0000);
        #20;
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            check("idle_after_reset", 16'h0000);
        end

        // Clean press and release on an active-high channel.
        debounce_seq(0, 1'b1, 1'b1, "clean_press");
        debounce_seq(0, 1'b0, 1'b0, "clean_release");

        // Three-cycle pulses never reach the acceptance threshold.
        for (int p = 0; p < 4; p++) begin
            btn_in[1] = (p % 2 == 0) ? 1'b1 : 1'b0;
            for (int k = 0; k < 3; k++) begin
                step();
                check("bounce_reject", 16'h0000);
            end
        end
        debounce_seq(1, 1'b1, 1'b1, "bounce_then_stable");
        debounce_seq(1, 1'b0, 1'b0, "bounce_release");

        // Active-low pad: driving 0 is a press.
        debounce_seq(3, 1'b0, 1'b1, "active_low_press");
        debounce_seq(3, 1'b1, 1'b0, "active_low_release");

        // Auto-repeat while held; release lands on a repeat slot (P+60).
        debounce_seq(2, 1'b1, 1'b1, "rpt_press");
        for (int j = 2; j <= 54; j++) begin
            step();
            rpt = (j >= c_hold && ((j - c_hold) % c_rep) == 0) ? 4'b0100 : 4'b0000;
            check("rpt_hold", {4'b0100, 4'b0000, 4'b0000, rpt});
        end
        debounce_seq(2, 1'b0, 1'b0, "rpt_release_on_slot");

        // Auto-repeat with the debounced release in cycle P+50.
        debounce_seq(2, 1'b1, 1'b1, "rpt2_press");
        for (int j = 2; j <= 56; j++) begin
            if (j == 45) btn_in[2] = 1'b0;
            step();
            lvl = (j < 50) ? 4'b0100 : 4'b0000;
            rel = (j == 50) ? 4'b0100 : 4'b0000;
            rpt = (j < 50 && j >= c_hold && ((j - c_hold) % c_rep) == 0) ? 4'b0100 : 4'b0000;
            check("rpt2_release", {lvl, 4'b0000, rel, rpt});
        end

        // Reset mid-hold: outputs drop at once, press re-fires without a release.
        debounce_seq(0, 1'b1, 1'b1, "midrst_press");
        for (int j = 2; j <= 25; j++) begin
            step();
            rpt = (j == c_hold) ? 4'b0001 : 4'b0000;
            check("midrst_hold", {4'b0001, 4'b0000, 4'b0000, rpt});
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_async_clear", 16'h0000);
        step();
        check("midrst_in_reset", 16'h0000);
        step();
        check("midrst_in_reset", 16'h0000);
        rst_n = 1'b1;
        for (int k = 1; k <= c_deb + 2; k++) begin
            step();
            if (k < c_deb + 2)
                check("midrst_reaccept", 16'h0000);
            else
                check("midrst_reaccept", {4'b0001, 4'b0001, 4'b0000, 4'b0000});
        end
        debounce_seq(0, 1'b0, 1'b0, "midrst_release");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
